mem_access_unit: RTL and testbench

//  Load/store sequencer between the memory-stage control and the data memory port.
//  - Accepts one byte/half/word access per handshake.
//  - Splits misaligned accesses into two aligned word transactions.
//  - Handles byte lanes and returns load data right-aligned and zero-filled.
//  - resp_size/resp_unsigned drive the downstream byte/half extenders.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2,
    DONE
  } mem_state_e;

  // Byte-enable pattern for an access placed at lane 0.
  function automatic logic [3:0] size_mask(input mem_size_e size);
    case (size)
      BYTE:    return 4'b0001;
      HALF:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Number of bytes moved by an access of the given size.
  function automatic logic [2:0] size_bytes(input mem_size_e size);
    case (size)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // The reserved size code behaves exactly like a word access.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the load/store sequencer.
// Stores are shifted into a two-word window; loads are merged from the two
// captured beats and shifted back down to bit 0.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned HALF_LEN = 16
) (
  input  logic [1:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] beat1_rdata_i,
  input  logic [31:0] beat2_rdata_i,
  output logic        split_o,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be_win;
  logic [63:0] st_win;
  logic [31:0] ld_hi;
  logic [31:0] ld_shift;
  logic [31:0] ld_mask;

  // An access splits when its last byte falls beyond the first word.
  always_comb begin
    split_o = ({1'b0, offset_i} + size_bytes(size_i)) > 3'd4;
  end

  // Store path: shift data and byte enables into the two-word window.
  always_comb begin
    be_win     = {4'b0000, size_mask(size_i)} << offset_i;
    st_win     = {32'b0, wdata_i} << {offset_i, 3'b000};
    be_lo_o    = be_win[3:0];
    be_hi_o    = be_win[7:4];
    wdata_lo_o = st_win[31:0];
    wdata_hi_o = st_win[63:32];
  end

  // Load path: merge beats, shift to bit 0 and zero everything above the size.
  always_comb begin
    ld_hi    = split_o ? beat2_rdata_i : '0;
    ld_shift = 32'({ld_hi, beat1_rdata_i} >> {offset_i, 3'b000});
    case (size_i)
      BYTE:    ld_mask = 32'h0000_00FF;
      HALF:    ld_mask = 32'((64'd1 << HALF_LEN) - 64'd1);
      default: ld_mask = '1;
    endcase
    rdata_o = ld_shift & ld_mask;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between memory-stage control and the data memory port.
// One request per handshake; misaligned accesses are issued as two aligned
// word beats and the load result is returned right-aligned, zero-filled.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned HALF_LEN    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic [1:0]             resp_size,
  output logic                   resp_unsigned,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic [3:0]             mem_be,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_LENGTH-1:0] mem_rdata
);

  mem_state_e             state_q, state_d;
  logic [WORD_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  mem_size_e              size_q;
  logic                   we_q;
  logic                   uns_q;
  logic [WORD_LENGTH-1:0] rdata1_q, rdata1_d;
  logic [WORD_LENGTH-1:0] rdata2_q, rdata2_d;

  logic                   accept;
  logic [WORD_LENGTH-1:0] word_base;
  logic [WORD_LENGTH-1:0] word_next;
  logic                   split;
  logic [3:0]             be_lo, be_hi;
  logic [WORD_LENGTH-1:0] wd_lo, wd_hi;
  logic [WORD_LENGTH-1:0] ld_data;

  mem_lane_align #(
    .HALF_LEN (HALF_LEN)
  ) u_align (
    .offset_i      (addr_q[1:0]),
    .size_i        (size_q),
    .wdata_i       (wdata_q),
    .beat1_rdata_i (rdata1_q),
    .beat2_rdata_i (rdata2_q),
    .split_o       (split),
    .be_lo_o       (be_lo),
    .be_hi_o       (be_hi),
    .wdata_lo_o    (wd_lo),
    .wdata_hi_o    (wd_hi),
    .rdata_o       (ld_data)
  );

  // Handshake and beat addresses; the second beat wraps modulo 2^32.
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    accept    = req_valid && req_ready;
    word_base = {addr_q[WORD_LENGTH-1:2], 2'b00};
    word_next = word_base + WORD_LENGTH'(4);
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: acks only matter while a beat is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = BEAT1;
      BEAT1: if (mem_ack) state_d = split ? BEAT2 : DONE;
      BEAT2: if (mem_ack) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-data capture for each beat, taken on that beat's ack.
  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (state_q == BEAT1 && mem_ack) rdata1_d = mem_rdata;
    if (state_q == BEAT2 && mem_ack) rdata2_d = mem_rdata;
  end

  // Request fields are latched once on accept and held for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= BYTE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= decode_size(req_size);
        we_q    <= req_we;
        uns_q   <= req_unsigned;
      end
    end
  end

  // Outputs decoded from state so they stay stable while waiting for ack.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    case (state_q)
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_base;
        mem_be    = be_lo;
        mem_wdata = we_q ? wd_lo : '0;
      end
      BEAT2: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_next;
        mem_be    = be_hi;
        mem_wdata = we_q ? wd_hi : '0;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : ld_data;
      end
      default: ;
    endcase
  end

  assign resp_size     = size_q;
  assign resp_unsigned = uns_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand sequences,
// and randomized accesses checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_size;
  logic        resp_unsigned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(
    .WORD_LENGTH (32),
    .HALF_LEN    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_size     (resp_size),
    .resp_unsigned (resp_unsigned),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Memory image: explicit words where preloaded, otherwise a fixed hash.
  logic [31:0] mem_img [bit [31:0]];

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (mem_img.exists(wa)) return mem_img[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] x);
    logic [31:0] w;
    w = rd_word({x[31:2], 2'b00});
    return w[8*x[1:0] +: 8];
  endfunction

  function automatic logic [31:0] lanemask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Observations of the most recent access.
  int unsigned g_beats;
  logic [31:0] g_addr [2];
  logic [3:0]  g_be   [2];
  logic [31:0] g_wd   [2];
  logic        g_we   [2];
  logic        g_done;
  int unsigned g_lat;
  logic [31:0] g_rdata;
  logic [1:0]  g_size;
  logic        g_uns;

  // Issue one request and act as the memory, acking each beat after dly cycles.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int unsigned dly);
    int unsigned cyc;
    int unsigned waitc;
    logic        stable;
    logic        quiet;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_be;
    logic        s_we;
    g_beats = 0;
    g_done  = 1'b0;
    g_lat   = 0;
    s_addr  = '0;
    s_wd    = '0;
    s_be    = '0;
    s_we    = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc    = 1;
    waitc  = 0;
    stable = 1'b1;
    quiet  = 1'b1;
    while (!g_done && cyc < 60) begin
      mem_ack = 1'b0;
      if (resp_valid) begin
        g_done  = 1'b1;
        g_lat   = cyc;
        g_rdata = resp_rdata;
        g_size  = resp_size;
        g_uns   = resp_unsigned;
        chk("ready_low_in_done", req_ready, 0);
      end else if (mem_req) begin
        if (waitc == 0) begin
          s_addr = mem_addr; s_be = mem_be; s_we = mem_we; s_wd = mem_wdata;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {s_addr, s_be, s_we, s_wd}) begin
          stable = 1'b0;
        end
        if (waitc < dly) begin
          waitc++;
          if (req_ready) quiet = 1'b0;
        end else begin
          if (g_beats < 2) begin
            g_addr[g_beats] = mem_addr;
            g_be[g_beats]   = mem_be;
            g_wd[g_beats]   = mem_wdata;
            g_we[g_beats]   = mem_we;
          end
          g_beats++;
          mem_rdata = rd_word(mem_addr);
          mem_ack   = 1'b1;
          waitc     = 0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    chk("resp_seen_in_budget", g_done, 1);
    if (dly > 0) begin
      chk("mem_stable_while_waiting", stable, 1);
      chk("ready_low_while_waiting", quiet, 1);
    end
    chk("resp_one_cycle_pulse", resp_valid, 0);
    chk("ready_back_after_done", req_ready, 1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    int unsigned dly;
    logic [31:0] pa1, pw1, pa2, pw2;
    int unsigned beats;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] a2;
    logic [3:0]  be2;
    logic [31:0] wd2;
    logic [31:0] rdata;
    logic [1:0]  rsz;
    int unsigned lat;
  } vec_t;

  vec_t vec [12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e_addr [2];
    logic [3:0]  e_be   [2];
    logic [31:0] e_wd   [2];
    logic [31:0] e_rdata;
    int unsigned e_beats;
    logic        r_we;
    logic [1:0]  r_sz;
    logic        r_uns;
    logic [31:0] r_addr, r_wd, x, wa;
    int unsigned r_dly, n, b;

    //          we  sz     uns addr          wd            dly pa1           pw1           pa2           pw2           bt a1            be1      wd1           a2            be2      wd2           rdata         rsz    lat
    vec[0]  = '{0, 2'd2, 0, 32'h0000_0100, 32'h0,        0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0,        1, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 2'd2, 2};
    vec[1]  = '{0, 2'd1, 0, 32'h0000_0103, 32'h0,        0, 32'h0000_0100, 32'hAA00_0000, 32'h0000_0104, 32'h0000_00BB, 2, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0104, 4'b0001, 32'h0,        32'h0000_BBAA, 2'd1, 3};
    vec[2]  = '{1, 2'd0, 0, 32'h0000_0202, 32'h0000_005A, 0, 32'h0000_0800, 32'h0,        32'h0000_0804, 32'h0,        1, 32'h0000_0200, 4'b0100, 32'h005A_0000, 32'h0,        4'b0000, 32'h0,        32'h0,         2'd0, 2};
    vec[3]  = '{1, 2'd2, 0, 32'h0000_0301, 32'h1122_3344, 0, 32'h0000_0800, 32'h0,        32'h0000_0804, 32'h0,        2, 32'h0000_0300, 4'b1110, 32'h2233_4400, 32'h0000_0304, 4'b0001, 32'h0000_0011, 32'h0,         2'd2, 3};
    vec[4]  = '{0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0,        0, 32'hFFFF_FFFC, 32'h1234_ABCD, 32'h0000_0000, 32'h5678_EF01, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0,        32'h0000_0000, 4'b0011, 32'h0,        32'hEF01_1234, 2'd2, 3};
    vec[5]  = '{0, 2'd1, 1, 32'h0000_0102, 32'h0,        0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0104, 32'h0,        1, 32'h0000_0100, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_CAFE, 2'd1, 2};
    vec[6]  = '{0, 2'd0, 0, 32'h0000_0107, 32'h0,        0, 32'h0000_0104, 32'h8011_2233, 32'h0000_0108, 32'h0,        1, 32'h0000_0104, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_0080, 2'd0, 2};
    vec[7]  = '{0, 2'd3, 1, 32'h0000_010C, 32'h0,        0, 32'h0000_010C, 32'h0102_0304, 32'h0000_0110, 32'h0,        1, 32'h0000_010C, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0102_0304, 2'd2, 2};
    vec[8]  = '{1, 2'd2, 0, 32'h0000_0400, 32'hA1B2_C3D4, 5, 32'h0000_0800, 32'h0,        32'h0000_0804, 32'h0,        1, 32'h0000_0400, 4'b1111, 32'hA1B2_C3D4, 32'h0,        4'b0000, 32'h0,        32'h0,         2'd2, 7};
    vec[9]  = '{1, 2'd1, 1, 32'h0000_0503, 32'h0000_BEEF, 0, 32'h0000_0800, 32'h0,        32'h0000_0804, 32'h0,        2, 32'h0000_0500, 4'b1000, 32'hEF00_0000, 32'h0000_0504, 4'b0001, 32'h0000_00BE, 32'h0,         2'd1, 3};
    vec[10] = '{0, 2'd1, 0, 32'h0000_01FE, 32'h0,        2, 32'h0000_01FC, 32'h7766_5544, 32'h0000_0200, 32'h0,        1, 32'h0000_01FC, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_7766, 2'd1, 4};
    vec[11] = '{0, 2'd2, 1, 32'h0000_0202, 32'h0,        1, 32'h0000_0200, 32'h4433_2211, 32'h0000_0204, 32'h8877_6655, 2, 32'h0000_0200, 4'b1100, 32'h0,        32'h0000_0204, 4'b0011, 32'h0,        32'h6655_4433, 2'd2, 5};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_size", resp_size, 0);
    chk("rst_resp_unsigned", resp_unsigned, 0);
    chk("rst_req_ready_low", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", req_ready, 1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      mem_img[vec[i].pa1] = vec[i].pw1;
      mem_img[vec[i].pa2] = vec[i].pw2;
      run_access(vec[i].we, vec[i].sz, vec[i].uns, vec[i].addr, vec[i].wd, vec[i].dly);
      chk($sformatf("tbl%0d_beats", i), g_beats, vec[i].beats);
      chk($sformatf("tbl%0d_a1", i), g_addr[0], vec[i].a1);
      chk($sformatf("tbl%0d_be1", i), g_be[0], vec[i].be1);
      chk($sformatf("tbl%0d_we1", i), g_we[0], vec[i].we);
      if (vec[i].we) chk($sformatf("tbl%0d_wd1", i), g_wd[0], vec[i].wd1);
      if (vec[i].beats == 2 && g_beats >= 2) begin
        chk($sformatf("tbl%0d_a2", i), g_addr[1], vec[i].a2);
        chk($sformatf("tbl%0d_be2", i), g_be[1], vec[i].be2);
        chk($sformatf("tbl%0d_we2", i), g_we[1], vec[i].we);
        if (vec[i].we) chk($sformatf("tbl%0d_wd2", i), g_wd[1], vec[i].wd2);
      end
      chk($sformatf("tbl%0d_rdata", i), g_rdata, vec[i].rdata);
      chk($sformatf("tbl%0d_rsize", i), g_size, vec[i].rsz);
      chk($sformatf("tbl%0d_runs", i), g_uns, vec[i].uns);
      chk($sformatf("tbl%0d_latency", i), g_lat, vec[i].lat);
    end

    // An ack while idle must not start anything
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_mem_req", mem_req, 0);
    chk("idle_ack_resp_valid", resp_valid, 0);
    chk("idle_ack_ready", req_ready, 1);

    // Reset abandons a split access sitting in its second beat
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h0000_0603; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstseq_beat1_addr", mem_addr, 32'h0000_0600);
    mem_rdata = rd_word(32'h0000_0600);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rstseq_beat2_req", mem_req, 1);
    chk("rstseq_beat2_addr", mem_addr, 32'h0000_0604);
    rst = 1'b1;
    @(negedge clk);
    chk("rstseq_mem_req", mem_req, 0);
    chk("rstseq_resp_valid", resp_valid, 0);
    chk("rstseq_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("rstseq_ready_after", req_ready, 1);
    @(negedge clk);
    chk("rstseq_no_late_resp", resp_valid, 0);
    chk("rstseq_no_late_req", mem_req, 0);

    // Randomized accesses against the byte-level model
    for (int t = 0; t < 150; t++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      if ($urandom_range(0, 9) == 0) r_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      r_wd   = $urandom;
      r_dly  = $urandom_range(0, 2);

      n = (r_sz == 2'd0) ? 1 : (r_sz == 2'd1) ? 2 : 4;
      e_addr[0] = {r_addr[31:2], 2'b00};
      e_addr[1] = '0;
      e_be[0] = '0; e_be[1] = '0;
      e_wd[0] = '0; e_wd[1] = '0;
      e_rdata = '0;
      e_beats = 1;
      for (int i = 0; i < n; i++) begin
        x  = r_addr + 32'(i);
        wa = {x[31:2], 2'b00};
        b  = (wa == e_addr[0]) ? 0 : 1;
        if (b == 1) begin
          e_beats   = 2;
          e_addr[1] = wa;
        end
        e_be[b][x[1:0]]       = 1'b1;
        e_wd[b][8*x[1:0] +: 8] = r_wd[8*i +: 8];
        e_rdata[8*i +: 8]      = rd_byte(x);
      end
      if (r_we) e_rdata = '0;

      run_access(r_we, r_sz, r_uns, r_addr, r_wd, r_dly);
      chk("rnd_beats", g_beats, e_beats);
      for (int k = 0; k < 2; k++) begin
        if (k < int'(e_beats) && k < int'(g_beats)) begin
          chk("rnd_addr", g_addr[k], e_addr[k]);
          chk("rnd_be", g_be[k], e_be[k]);
          chk("rnd_we", g_we[k], r_we);
          if (r_we) chk("rnd_wdata_lanes", g_wd[k] & lanemask(e_be[k]), e_wd[k]);
        end
      end
      chk("rnd_rdata", g_rdata, e_rdata);
      chk("rnd_rsize", g_size, (r_sz == 2'd3) ? 2'd2 : r_sz);
      chk("rnd_runs", g_uns, r_uns);
      chk("rnd_latency", g_lat, e_beats * (1 + r_dly) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
